// File: rtl/bram_sdp_reader_if.sv
// Request/response stream bundle for the BRAM port-B read controller.
// The master side issues read addresses and consumes the returned data.
interface bram_sdp_reader_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/bram_sdp_reader.sv
// BRAM port-B read controller: valid/ready requests in, in-order responses out,
// 2-entry skid buffer and write-first forwarding of same-cycle port-A writes.
module bram_sdp_reader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bram_sdp_reader_if.slave      bus,
   output logic                  bram_enb,
   output logic [ADDR_WIDTH-1:0] bram_addrb,
   input  logic [DATA_WIDTH-1:0] bram_dob,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic                  inflight;
   logic [1:0]            cnt;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic                  hit;
   logic [DATA_WIDTH-1:0] byp_data;
   logic [DATA_WIDTH-1:0] buf_mem [2];

   logic [1:0]            occ;
   logic                  pop;
   logic                  accept;
   logic                  capture;
   logic                  release_buf;
   logic [DATA_WIDTH-1:0] read_data;

   always_comb begin
      occ           = cnt + {1'b0, inflight};
      read_data     = hit ? byp_data : bram_dob;
      bus.rsp_valid = (cnt != 2'd0) || inflight;
      bus.rsp_data  = (cnt != 2'd0) ? buf_mem[rd_ptr] : read_data;
      pop           = bus.rsp_valid && bus.rsp_ready;
      // Gated by rst_n so no request is taken (or BRAM read issued) during reset.
      bus.req_ready = rst_n && ((occ < 2'd2) || pop);
      accept        = bus.req_valid && bus.req_ready;
      // Fall-through: data popped in its first cycle never enters the buffer.
      capture       = inflight && !((cnt == 2'd0) && pop);
      release_buf   = pop && (cnt != 2'd0);
   end

   assign bram_enb   = accept;
   assign bram_addrb = bus.req_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         cnt      <= '0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         hit      <= 1'b0;
      end else begin
         inflight <= accept;
         cnt      <= cnt + {1'b0, capture} - {1'b0, release_buf};
         if (capture)
            wr_ptr <= ~wr_ptr;
         if (release_buf)
            rd_ptr <= ~rd_ptr;
         if (accept)
            hit <= wr_en && (wr_addr == bus.req_addr);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         byp_data <= wr_data;
      if (capture)
         buf_mem[wr_ptr] <= read_data;
   end

endmodule
